// File: rtl/pll_lock_monitor.sv
// PLL lock qualifier: drives the PLL reset, filters raw lock in both directions,
// retries a bounded number of times on lock timeout and then flags a sticky failure.
module pll_lock_monitor #(
  parameter int unsigned LOCK_STABLE_CYCLES   = 1024,
  parameter int unsigned UNLOCK_FILTER_CYCLES = 4,
  parameter int unsigned PLL_RST_CYCLES       = 64,
  parameter int unsigned LOCK_TIMEOUT_CYCLES  = 65536,
  parameter int unsigned MAX_RETRY            = 7
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_pll_lock_raw,
  output logic       O_pll_rst,
  output logic       O_pll_lock,
  output logic       O_lock_lost,
  output logic [2:0] O_retry_cnt,
  output logic       O_fail
);

  localparam int unsigned QW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned UW = $clog2(UNLOCK_FILTER_CYCLES + 1);
  localparam int unsigned PW = $clog2(PLL_RST_CYCLES + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int unsigned RW = 3;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_QUALIFY   = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [PW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [QW-1:0]   qual_cnt_q, qual_cnt_d;
  logic [UW-1:0]   unl_cnt_q, unl_cnt_d;
  logic            pll_rst_q, pll_rst_d;
  logic            pll_lock_q, pll_lock_d;
  logic            lock_lost_q, lock_lost_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            fail_q, fail_d;
  logic            sync_lock;

  assign sync_lock = sync2_q;

  // State and output registers; synchronizer flops are reset as well.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q     <= ST_PLL_RST;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      qual_cnt_q  <= '0;
      unl_cnt_q   <= '0;
      pll_rst_q   <= 1'b1;
      pll_lock_q  <= 1'b0;
      lock_lost_q <= 1'b0;
      retry_q     <= '0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      qual_cnt_q  <= qual_cnt_d;
      unl_cnt_q   <= unl_cnt_d;
      pll_rst_q   <= pll_rst_d;
      pll_lock_q  <= pll_lock_d;
      lock_lost_q <= lock_lost_d;
      retry_q     <= retry_d;
      fail_q      <= fail_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    sync1_d     = I_pll_lock_raw;
    sync2_d     = sync1_q;
    rst_cnt_d   = rst_cnt_q;
    to_cnt_d    = to_cnt_q;
    qual_cnt_d  = qual_cnt_q;
    unl_cnt_d   = unl_cnt_q;
    pll_rst_d   = pll_rst_q;
    pll_lock_d  = pll_lock_q;
    lock_lost_d = 1'b0;
    retry_d     = retry_q;
    fail_d      = fail_q;

    case (state_q)
      ST_PLL_RST: begin
        pll_rst_d  = 1'b1;
        pll_lock_d = 1'b0;
        if (rst_cnt_q == PW'(PLL_RST_CYCLES - 1)) begin
          state_d    = ST_WAIT_LOCK;
          pll_rst_d  = 1'b0;
          rst_cnt_d  = '0;
          to_cnt_d   = '0;
          qual_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + PW'(1);
        end
      end

      ST_WAIT_LOCK, ST_QUALIFY: begin
        pll_rst_d = 1'b0;
        to_cnt_d  = to_cnt_q + TW'(1);
        if (sync_lock) begin
          qual_cnt_d = qual_cnt_q + QW'(1);
          state_d    = ST_QUALIFY;
        end else begin
          qual_cnt_d = '0;
          state_d    = ST_WAIT_LOCK;
        end
        // Qualification takes priority over a coincident timeout.
        if (sync_lock && (qual_cnt_q == QW'(LOCK_STABLE_CYCLES - 1))) begin
          state_d    = ST_LOCKED;
          pll_lock_d = 1'b1;
          retry_d    = '0;
          qual_cnt_d = '0;
          to_cnt_d   = '0;
          unl_cnt_d  = '0;
        end else if (to_cnt_q == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          to_cnt_d   = '0;
          qual_cnt_d = '0;
          pll_rst_d  = 1'b1;
          if (({1'b0, retry_q} + 4'd1) < 4'(MAX_RETRY)) begin
            retry_d   = retry_q + RW'(1);
            rst_cnt_d = '0;
            state_d   = ST_PLL_RST;
          end else begin
            retry_d = RW'(MAX_RETRY);
            fail_d  = 1'b1;
            state_d = ST_FAIL;
          end
        end
      end

      ST_LOCKED: begin
        pll_rst_d = 1'b0;
        if (sync_lock) begin
          unl_cnt_d = '0;
        end else if (unl_cnt_q == UW'(UNLOCK_FILTER_CYCLES - 1)) begin
          state_d     = ST_PLL_RST;
          pll_lock_d  = 1'b0;
          lock_lost_d = 1'b1;
          pll_rst_d   = 1'b1;
          rst_cnt_d   = '0;
          unl_cnt_d   = '0;
        end else begin
          unl_cnt_d = unl_cnt_q + UW'(1);
        end
      end

      ST_FAIL: begin
        fail_d     = 1'b1;
        pll_rst_d  = 1'b1;
        pll_lock_d = 1'b0;
      end

      default: begin
        state_d    = ST_PLL_RST;
        pll_rst_d  = 1'b1;
        pll_lock_d = 1'b0;
        rst_cnt_d  = '0;
        to_cnt_d   = '0;
        qual_cnt_d = '0;
        unl_cnt_d  = '0;
      end
    endcase
  end

  assign O_pll_rst   = pll_rst_q;
  assign O_pll_lock  = pll_lock_q;
  assign O_lock_lost = lock_lost_q;
  assign O_retry_cnt = retry_q;
  assign O_fail      = fail_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Self-checking bench for pll_lock_monitor: directed scenarios plus randomized
// raw-lock bursts compared against a behavioural model.
module tb_pll_lock_monitor;

  localparam int unsigned N  = 16;
  localparam int unsigned U  = 4;
  localparam int unsigned P  = 8;
  localparam int unsigned T  = 100;
  localparam int unsigned MR = 3;

  logic       clk;
  logic       rst_n;
  logic       raw;
  logic       pll_rst, pll_lock, lock_lost, fail;
  logic [2:0] retry_cnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: phase 0 reset pulse, 1 waiting for lock, 2 locked, 3 failed.
  int m_phase, m_rst_el, m_wait_el, m_high, m_low, m_retry;
  bit m_s1, m_s2, m_rst, m_lock, m_lost, m_fail;

  pll_lock_monitor #(
    .LOCK_STABLE_CYCLES  (N),
    .UNLOCK_FILTER_CYCLES(U),
    .PLL_RST_CYCLES      (P),
    .LOCK_TIMEOUT_CYCLES (T),
    .MAX_RETRY           (MR)
  ) dut (
    .I_clk         (clk),
    .I_rst_n       (rst_n),
    .I_pll_lock_raw(raw),
    .O_pll_rst     (pll_rst),
    .O_pll_lock    (pll_lock),
    .O_lock_lost   (lock_lost),
    .O_retry_cnt   (retry_cnt),
    .O_fail        (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0; m_rst_el = 0; m_wait_el = 0; m_high = 0; m_low = 0;
    m_s1 = 0; m_s2 = 0; m_rst = 1; m_lock = 0; m_lost = 0; m_retry = 0; m_fail = 0;
  endtask

  task automatic model_step();
    bit s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = m_s2;
    m_s2 = m_s1;
    m_s1 = raw;
    m_lost = 0;
    case (m_phase)
      0: begin
        m_rst_el++;
        if (m_rst_el == int'(P)) begin
          m_phase = 1; m_wait_el = 0; m_high = 0; m_rst = 0;
        end
      end
      1: begin
        m_wait_el++;
        m_high = s ? m_high + 1 : 0;
        if (m_high == int'(N)) begin
          m_phase = 2; m_lock = 1; m_retry = 0; m_low = 0;
        end else if (m_wait_el == int'(T)) begin
          m_rst = 1;
          if (m_retry + 1 < int'(MR)) begin
            m_retry++; m_phase = 0; m_rst_el = 0;
          end else begin
            m_retry = int'(MR); m_phase = 3; m_fail = 1;
          end
        end
      end
      2: begin
        m_low = s ? 0 : m_low + 1;
        if (m_low == int'(U)) begin
          m_lock = 0; m_lost = 1; m_rst = 1; m_phase = 0; m_rst_el = 0;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [6:0] dut_vec();
    return {pll_rst, pll_lock, lock_lost, retry_cnt, fail};
  endfunction

  function automatic logic [6:0] mdl_vec();
    return {m_rst, m_lock, m_lost, 3'(m_retry), m_fail};
  endfunction

  // One clock: model advances on the active edge, outputs settle by the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic reset_seq();
    rst_n = 1'b0;
    raw   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int hi;
    rst_n = 1'b0;
    raw   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_vec() !== 7'b1000000) begin
        failures++; $display("FAIL reset_vals got=%b exp=%b", dut_vec(), 7'b1000000);
      end
    end
    rst_n = 1'b1;
    hi = int'(pll_rst);
    for (int i = 0; i < 20; i++) begin
      tick();
      hi += int'(pll_rst);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++; $display("FAIL rst_seq got=%b exp=%b", dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (hi != int'(P)) begin
      failures++; $display("FAIL rst_pulse_len got=%0d exp=%0d", hi, P);
    end
    raw = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 17) begin
        checks++;
        if (pll_lock !== 1'b0) begin
          failures++; $display("FAIL lock_early got=%b exp=0", pll_lock);
        end
      end
      if (k == 18) begin
        checks++;
        if ({pll_lock, retry_cnt} !== 4'b1000) begin
          failures++; $display("FAIL lock_latency got=%b exp=%b", {pll_lock, retry_cnt}, 4'b1000);
        end
      end
    end
  endtask

  task automatic test_qualify_glitch();
    bit rst_seen;
    reset_seq();
    for (int i = 0; i < 12; i++) tick();
    rst_seen = 1'b0;
    raw = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); rst_seen |= pll_rst; end
    raw = 1'b0;
    tick();
    rst_seen |= pll_rst;
    raw = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      rst_seen |= pll_rst;
      checks++;
      if (pll_lock !== ((k == 18) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL qual_glitch k=%0d got=%b exp=%b", k, pll_lock, (k == 18));
      end
    end
    checks++;
    if (rst_seen !== 1'b0) begin
      failures++; $display("FAIL qual_no_rst got=%b exp=0", rst_seen);
    end
  endtask

  task automatic test_unlock_filter();
    int hi;
    raw = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) raw = 1'b1;
      tick();
      checks++;
      if ({pll_lock, lock_lost, pll_rst} !== 3'b100) begin
        failures++; $display("FAIL glitch_reject got=%b exp=100", {pll_lock, lock_lost, pll_rst});
      end
    end
    raw = 1'b0;
    hi = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k >= 6) hi += int'(pll_rst);
      if (k == 5) begin
        checks++;
        if ({pll_lock, lock_lost} !== 2'b10) begin
          failures++; $display("FAIL unlock_early got=%b exp=10", {pll_lock, lock_lost});
        end
      end
      if (k == 6) begin
        checks++;
        if ({pll_lock, lock_lost, pll_rst} !== 3'b011) begin
          failures++; $display("FAIL unlock_latency got=%b exp=011", {pll_lock, lock_lost, pll_rst});
        end
      end
      if (k == 7) begin
        checks++;
        if (lock_lost !== 1'b0) begin
          failures++; $display("FAIL lost_pulse got=%b exp=0", lock_lost);
        end
      end
    end
    checks++;
    if (hi != int'(P) || retry_cnt !== 3'd0) begin
      failures++; $display("FAIL unlock_rst_pulse got=%0d/%0d exp=%0d/0", hi, retry_cnt, P);
    end
  endtask

  task automatic test_retry_fail();
    int t1, t2, t3, hi;
    bit fail_early;
    reset_seq();
    t1 = 0; t2 = 0; t3 = 0; hi = 0; fail_early = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (retry_cnt == 3'd1 && t1 == 0) t1 = i;
      if (retry_cnt == 3'd2 && t2 == 0) t2 = i;
      if (retry_cnt == 3'd3 && t3 == 0) t3 = i;
      if (t1 != 0 && t2 == 0) hi += int'(pll_rst);
      if (t3 == 0 && fail === 1'b1) fail_early = 1;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        if (failures <= 40) $display("FAIL retry_seq i=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (t1 != int'(P + T) || (t2 - t1) != int'(P + T) || (t3 - t2) != int'(P + T)) begin
      failures++; $display("FAIL retry_times got=%0d,%0d,%0d exp=%0d step %0d", t1, t2, t3, P + T, P + T);
    end
    checks++;
    if (hi != int'(P) || fail_early) begin
      failures++; $display("FAIL retry_rst_pulse got=%0d early_fail=%0d exp=%0d", hi, fail_early, P);
    end
    raw = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({pll_rst, pll_lock, retry_cnt, fail} !== 6'b100111) begin
        failures++;
        if (failures <= 40) $display("FAIL fail_hold got=%b exp=100111", {pll_rst, pll_lock, retry_cnt, fail});
      end
    end
  endtask

  task automatic test_lock_on_timeout();
    reset_seq();
    for (int i = 1; i <= 216; i++) begin
      if (i == 199) raw = 1'b1;
      tick();
      if (i == 215) begin
        checks++;
        if ({pll_lock, retry_cnt} !== 4'b0001) begin
          failures++; $display("FAIL pre_timeout got=%b exp=0001", {pll_lock, retry_cnt});
        end
      end
      if (i == 216) begin
        checks++;
        if ({pll_rst, pll_lock, retry_cnt, fail} !== 6'b010000) begin
          failures++; $display("FAIL lock_wins got=%b exp=010000", {pll_rst, pll_lock, retry_cnt, fail});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int hi;
    for (int pass = 0; pass < 2; pass++) begin
      reset_seq();
      raw = (pass == 0);
      for (int i = 0; i < ((pass == 0) ? 30 : 340); i++) tick();
      checks++;
      if ((pass == 0 && pll_lock !== 1'b1) || (pass == 1 && fail !== 1'b1)) begin
        failures++; $display("FAIL mid_pre pass=%0d got=%b", pass, dut_vec());
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (dut_vec() !== 7'b1000000) begin
        failures++; $display("FAIL mid_reset pass=%0d got=%b exp=1000000", pass, dut_vec());
      end
      rst_n = 1'b1;
      raw = 1'b0;
      hi = int'(pll_rst);
      for (int i = 0; i < 15; i++) begin tick(); hi += int'(pll_rst); end
      checks++;
      if (hi != int'(P)) begin
        failures++; $display("FAIL mid_restart pass=%0d got=%0d exp=%0d", pass, hi, P);
      end
    end
  endtask

  task automatic test_random();
    int len;
    bit val;
    reset_seq();
    len = 0;
    val = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (len == 0) begin
        val = ~val;
        if (val) len = int'($urandom_range(1, 40));
        else if ($urandom_range(0, 9) == 0) len = int'($urandom_range(100, 250));
        else len = int'($urandom_range(1, 8));
      end
      raw = val;
      len--;
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        if (failures <= 40) $display("FAIL random i=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    raw   = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_qualify_glitch();
    test_unlock_filter();
    test_retry_fail();
    test_lock_on_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
